// File: rtl/dmem_responder.sv
// Word-addressed data memory answering MEM-stage loads/stores after a fixed
// latency, freezing the pipeline via stall_o until the one-cycle ack_o.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          enter_resp;

    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          op_we;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic          op_err;
    logic [IW-1:0] op_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        stall_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_o = req_i;
                if (req_i) begin
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With LATENCY=1 the access resolves on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-latched copies.
    always_comb begin
        if (state_q == IDLE) begin
            op_we    = we_i;
            op_addr  = addr_i;
            op_wdata = wdata_i;
        end else begin
            op_we    = we_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
        op_err = (op_addr[1:0] != 2'b00) || (op_addr[31:IW+2] != '0);
        op_idx = op_addr[IW+1:2];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            ack_o <= enter_resp;
            err_o <= enter_resp && op_err;
            if (enter_resp) begin
                if (op_err) begin
                    rdata_o <= '0;
                end else if (!op_we) begin
                    rdata_o <= mem[op_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && op_we && !op_err) begin
            mem[op_idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder (LATENCY=3 and LATENCY=1).
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, req_a, we_a, ack_a, err_a, stall_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        rst_b, req_b, we_b, ack_b, err_b, stall_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .rdata_o(rdata_a),
        .ack_o(ack_a), .err_o(err_a), .stall_o(stall_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .rdata_o(rdata_b),
        .ack_o(ack_b), .err_o(err_b), .stall_o(stall_b)
    );

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [31:0] mm [2][DEPTH];
    logic [31:0] last [2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Reference: the response each access must produce, from the rules alone.
    function automatic exp_t model(input int u, input bit we,
                                   input logic [31:0] a,
                                   input logic [31:0] d, input int due);
        exp_t e;
        int   idx;
        e.cyc = due;
        e.err = (a % 4 != 0) || ((a / 4) >= DEPTH);
        if (e.err) begin
            e.rdata = 32'h0;
            last[u] = 32'h0;
        end else begin
            idx = int'(a / 4);
            if (we) begin
                mm[u][idx] = d;
                e.rdata = last[u];
            end else begin
                e.rdata = mm[u][idx];
                last[u] = e.rdata;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_addr();
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        end else if (r == 1) begin
            a = $urandom() | 32'h400;
            a[1:0] = 2'b00;
        end else begin
            a = 32'($urandom_range(0, 15)) * 4;
        end
        return a;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (ack_a) begin
                if (q_a.size() == 0) begin
                    chk("unexpected_ack_a", 32'(ack_a), 32'h0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    chk("err_a", 32'(err_a), 32'(e.err));
                    chk("rdata_a", rdata_a, e.rdata);
                    chk("ack_cycle_a", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("err_idle_a", 32'(err_a), 32'h0);
            end
            if (ack_b) begin
                if (q_b.size() == 0) begin
                    chk("unexpected_ack_b", 32'(ack_b), 32'h0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    chk("err_b", 32'(err_b), 32'(e.err));
                    chk("rdata_b", rdata_b, e.rdata);
                    chk("ack_cycle_b", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("err_idle_b", 32'(err_b), 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access on the LATENCY=3 instance; called at the start of an
    // idle cycle, returns at the start of the cycle after the ack.
    task automatic acc_a(input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit churn);
        req_a = 1'b1;
        we_a = we;
        addr_a = a;
        wdata_a = d;
        #1;
        chk("stall_accept_a", 32'(stall_a), 32'h1);
        q_a.push_back(model(0, we, a, d, cyc + LAT_A));
        step();
        req_a = 1'b0;
        for (int i = 1; i < LAT_A; i++) begin
            if (churn) begin
                req_a = 1'($urandom_range(0, 1));
                we_a = 1'($urandom_range(0, 1));
                addr_a = $urandom();
                wdata_a = $urandom();
            end
            #1;
            chk("stall_busy_a", 32'(stall_a), 32'h1);
            step();
        end
        req_a = 1'b0;
        #1;
        chk("stall_resp_a", 32'(stall_a), 32'h0);
        step();
    endtask

    // Back-to-back accesses on the LATENCY=1 instance with req held high.
    task automatic burst_b(input int n, input bit fixed_start);
        logic [31:0] a;
        bit we;
        req_b = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (fixed_start && k < 2) begin
                we = 1'b0;
                a = 32'(k * 4);
            end else begin
                we = 1'($urandom_range(0, 1));
                a = gen_addr();
            end
            we_b = we;
            addr_b = a;
            wdata_b = $urandom();
            #1;
            chk("stall_accept_b", 32'(stall_b), 32'h1);
            q_b.push_back(model(1, we, a, wdata_b, cyc + LAT_B));
            step();
            #1;
            chk("stall_resp_b", 32'(stall_b), 32'h0);
            step();
        end
        req_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b1; req_a = 1'b0; we_a = 1'b0;
        addr_a = '0; wdata_a = '0;
        rst_b = 1'b1; req_b = 1'b0; we_b = 1'b0;
        addr_b = '0; wdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mm[0][i] = $urandom();
            mm[1][i] = $urandom();
        end
        mm[1][0] = 32'h11;
        mm[1][1] = 32'h22;
        for (int i = 0; i < DEPTH; i++) begin
            dut_a.mem[i] = mm[0][i];
            dut_b.mem[i] = mm[1][i];
        end
        last[0] = 32'h0;
        last[1] = 32'h0;

        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        mon_on = 1'b1;
        chk("rst_ack_a", 32'(ack_a), 32'h0);
        chk("rst_err_a", 32'(err_a), 32'h0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_stall_a", 32'(stall_a), 32'h0);
        chk("rst_rdata_b", rdata_b, 32'h0);
        chk("rst_stall_b", 32'(stall_b), 32'h0);
        req_a = 1'b1;
        req_b = 1'b1;
        #1;
        chk("comb_stall_a", 32'(stall_a), 32'h1);
        chk("comb_stall_b", 32'(stall_b), 32'h1);
        req_a = 1'b0;
        req_b = 1'b0;
        step();

        acc_a(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        acc_a(1'b0, 32'h10, 32'h0, 1'b0);
        acc_a(1'b0, 32'h13, 32'h0, 1'b0);
        acc_a(1'b1, 32'h400, 32'hCAFEF00D, 1'b0);
        acc_a(1'b0, 32'h0, 32'h0, 1'b0);
        acc_a(1'b1, 32'h20, 32'hA5A5A5A5, 1'b1);
        acc_a(1'b0, 32'h20, 32'h0, 1'b0);

        acc_a(1'b1, 32'h8, 32'h0, 1'b0);
        req_a = 1'b1;
        we_a = 1'b1;
        addr_a = 32'h8;
        wdata_a = 32'h12345678;
        step();
        req_a = 1'b0;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        last[0] = 32'h0;
        chk("midrst_ack_a", 32'(ack_a), 32'h0);
        chk("midrst_stall_a", 32'(stall_a), 32'h0);
        chk("midrst_rdata_a", rdata_a, 32'h0);
        for (int i = 0; i < 5; i++) step();
        acc_a(1'b0, 32'h8, 32'h0, 1'b0);

        burst_b(2, 1'b1);
        step();

        for (int i = 0; i < 40; i++) begin
            acc_a(1'($urandom_range(0, 1)), gen_addr(), $urandom(),
                  1'($urandom_range(0, 1)));
        end
        burst_b(30, 1'b0);

        for (int i = 0; i < 6; i++) step();
        chk("pending_a", 32'(q_a.size()), 32'h0);
        chk("pending_b", 32'(q_b.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
